// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl
//   Moves a rectangular sprite around the visible screen, either from the
//   push buttons (manual) or by bouncing off the screen edges (auto). A
//   programmable divider sets how often the sprite moves. Also produces the
//   per-pixel overlay flag used by the VGA colour mux.
//
//   Optional feature macro: SPRITE_BTN_SYNC_EN
//     When defined, the four buttons and mode pass through two-flop
//     synchronisers (reset to 0) before use.
//
// Ports
//   clk            system clock, all state on its rising edge
//   rst            asynchronous, active-low reset
//   btn_right/left/up/down  active-high button requests
//   mode           0 = manual, 1 = auto-bounce (sampled on move ticks)
//   xPixel, yPixel current raster coordinate from vga_driver
//   active_pixels  visible-region flag from vga_driver
//   spr_x, spr_y   sprite top-left corner
//   dir_x, dir_y   1 = moving right / down
//   move_tick      one-clock pulse marking each update edge
//   bounce_cnt     wall bounce count, wraps modulo 256
//   corner         one-clock pulse when both axes bounce on the same tick
//   in_sprite      combinational overlay flag
module sprite_motion_ctrl #(
  parameter int CW       = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int SPR_W    = 30,
  parameter int SPR_H    = 30,
  parameter int STEP     = 4,
  parameter int DIV      = 2097152,
  parameter int X0       = 50,
  parameter int Y0       = 225
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          btn_right,
  input  logic          btn_left,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          mode,
  input  logic [CW-1:0] xPixel,
  input  logic [CW-1:0] yPixel,
  input  logic          active_pixels,
  output logic [CW-1:0] spr_x,
  output logic [CW-1:0] spr_y,
  output logic          dir_x,
  output logic          dir_y,
  output logic          move_tick,
  output logic [7:0]    bounce_cnt,
  output logic          corner,
  output logic          in_sprite
);

  localparam int DW = $clog2(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  // All limit arithmetic is done one bit wider than a coordinate so that
  // pos+STEP can never wrap before being clamped.
  localparam logic [CW:0]   XMAX_W = (CW+1)'(SCREEN_W - SPR_W);
  localparam logic [CW:0]   YMAX_W = (CW+1)'(SCREEN_H - SPR_H);
  localparam logic [CW-1:0] XMAX_C = CW'(SCREEN_W - SPR_W);
  localparam logic [CW-1:0] YMAX_C = CW'(SCREEN_H - SPR_H);
  localparam logic [CW:0]   STEP_W = (CW+1)'(STEP);
  localparam logic [CW-1:0] STEP_C = CW'(STEP);
  localparam logic [CW:0]   SPRW_W = (CW+1)'(SPR_W);
  localparam logic [CW:0]   SPRH_W = (CW+1)'(SPR_H);

  typedef enum logic {MANUAL, AUTO} state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;

  logic right_s, left_s, up_s, down_s, mode_s;

`ifdef SPRITE_BTN_SYNC_EN
  logic [4:0] sync1;
  logic [4:0] sync2;

  // Two-flop synchronisers for asynchronous button and mode sources.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {mode, btn_down, btn_up, btn_left, btn_right};
      sync2 <= sync1;
    end
  end

  assign {mode_s, down_s, up_s, left_s, right_s} = sync2;
`else
  assign right_s = btn_right;
  assign left_s  = btn_left;
  assign up_s    = btn_up;
  assign down_s  = btn_down;
  assign mode_s  = mode;
`endif

  // Positive step clamped to the axis limit.
  function automatic logic [CW-1:0] step_up(input logic [CW-1:0] pos,
                                            input logic [CW:0]   lim);
    logic [CW:0] sum;
    sum = {1'b0, pos} + STEP_W;
    return (sum >= lim) ? lim[CW-1:0] : sum[CW-1:0];
  endfunction

  // Negative step clamped at zero.
  function automatic logic [CW-1:0] step_dn(input logic [CW-1:0] pos);
    return ({1'b0, pos} < STEP_W) ? '0 : (pos - STEP_C);
  endfunction

  logic [CW-1:0] x_up, x_dn, y_up, y_dn;
  logic          x_bounce, y_bounce;

  assign x_up = step_up(spr_x, XMAX_W);
  assign x_dn = step_dn(spr_x);
  assign y_up = step_up(spr_y, YMAX_W);
  assign y_dn = step_dn(spr_y);

  // In auto mode an axis bounces whenever its next position lands on a
  // limit, including a sprite already parked there and pointing outward.
  assign x_bounce = dir_x ? (x_up == XMAX_C) : (x_dn == '0);
  assign y_bounce = dir_y ? (y_up == YMAX_C) : (y_dn == '0);

  assign move_tick = (div_cnt == DIV_LAST);

  // Divider, mode FSM and all motion registers. The mode change lands on
  // the tick edge, but that edge still moves according to the old state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt    <= '0;
      state      <= mode_s ? AUTO : MANUAL;
      spr_x      <= CW'(X0);
      spr_y      <= CW'(Y0);
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
      bounce_cnt <= '0;
      corner     <= 1'b0;
    end else begin
      corner  <= 1'b0;
      div_cnt <= move_tick ? '0 : div_cnt + 1'b1;
      if (move_tick) begin
        state <= mode_s ? AUTO : MANUAL;
        case (state)
          MANUAL: begin
            if (right_s && !left_s) begin
              spr_x <= x_up;
              dir_x <= 1'b1;
            end else if (left_s && !right_s) begin
              spr_x <= x_dn;
              dir_x <= 1'b0;
            end
            if (down_s && !up_s) begin
              spr_y <= y_up;
              dir_y <= 1'b1;
            end else if (up_s && !down_s) begin
              spr_y <= y_dn;
              dir_y <= 1'b0;
            end
          end
          AUTO: begin
            spr_x <= dir_x ? x_up : x_dn;
            spr_y <= dir_y ? y_up : y_dn;
            if (x_bounce) dir_x <= ~dir_x;
            if (y_bounce) dir_y <= ~dir_y;
            if (x_bounce || y_bounce) bounce_cnt <= bounce_cnt + 8'd1;
            corner <= x_bounce && y_bounce;
          end
          default: ;
        endcase
      end
    end
  end

  // Overlay test widened by one bit so spr+SPR_W cannot wrap.
  assign in_sprite = active_pixels
                   && ({1'b0, xPixel} >= {1'b0, spr_x})
                   && ({1'b0, xPixel} <  ({1'b0, spr_x} + SPRW_W))
                   && ({1'b0, yPixel} >= {1'b0, spr_y})
                   && ({1'b0, yPixel} <  ({1'b0, spr_y} + SPRH_W));

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl
//   Three copies of the controller with DIV=4, STEP=4 share all inputs and
//   differ only in their reset position: A at (50,225), B at (608,225) and
//   C at (606,446), so every edge case is reachable without a load port.
module tb_sprite_motion_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_right = 1'b0, btn_left = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       mode = 1'b0;
  logic [9:0] xPixel = '0, yPixel = '0;
  logic       active_pixels = 1'b0;

  logic [9:0] a_x, a_y, b_x, b_y, c_x, c_y;
  logic       a_dx, a_dy, b_dx, b_dy, c_dx, c_dy;
  logic       a_tick, b_tick, c_tick;
  logic [7:0] a_bc, b_bc, c_bc;
  logic       a_corner, b_corner, c_corner;
  logic       a_in, b_in, c_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sprite_motion_ctrl #(.DIV(4), .STEP(4), .X0(50), .Y0(225)) dut_a (
    .clk(clk), .rst(rst), .btn_right(btn_right), .btn_left(btn_left),
    .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
    .xPixel(xPixel), .yPixel(yPixel), .active_pixels(active_pixels),
    .spr_x(a_x), .spr_y(a_y), .dir_x(a_dx), .dir_y(a_dy),
    .move_tick(a_tick), .bounce_cnt(a_bc), .corner(a_corner), .in_sprite(a_in));

  sprite_motion_ctrl #(.DIV(4), .STEP(4), .X0(608), .Y0(225)) dut_b (
    .clk(clk), .rst(rst), .btn_right(btn_right), .btn_left(btn_left),
    .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
    .xPixel(xPixel), .yPixel(yPixel), .active_pixels(active_pixels),
    .spr_x(b_x), .spr_y(b_y), .dir_x(b_dx), .dir_y(b_dy),
    .move_tick(b_tick), .bounce_cnt(b_bc), .corner(b_corner), .in_sprite(b_in));

  sprite_motion_ctrl #(.DIV(4), .STEP(4), .X0(606), .Y0(446)) dut_c (
    .clk(clk), .rst(rst), .btn_right(btn_right), .btn_left(btn_left),
    .btn_up(btn_up), .btn_down(btn_down), .mode(mode),
    .xPixel(xPixel), .yPixel(yPixel), .active_pixels(active_pixels),
    .spr_x(c_x), .spr_y(c_y), .dir_x(c_dx), .dir_y(c_dy),
    .move_tick(c_tick), .bounce_cnt(c_bc), .corner(c_corner), .in_sprite(c_in));

  typedef struct {
    int xp;
    int yp;
    bit act;
    bit exp_in;
  } ovl_vec_t;

  typedef struct {
    bit r;
    bit l;
    bit u;
    bit d;
    int ex;
    int ey;
    bit edx;
    bit edy;
  } man_vec_t;

  ovl_vec_t ovl[8];
  man_vec_t man[8];

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input bit r, input bit l, input bit u, input bit d);
    btn_right = r;
    btn_left  = l;
    btn_up    = u;
    btn_down  = d;
  endtask

  // Waits for the next update edge and returns 1 ns after it.
  task automatic next_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_tick) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_output("tick_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input bit mode_v);
    @(negedge clk);
    apply_stimulus(0, 0, 0, 0);
    mode = mode_v;
    rst  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int first_edge;

    ovl[0] = '{49, 225, 1'b1, 1'b0};
    ovl[1] = '{50, 225, 1'b1, 1'b1};
    ovl[2] = '{79, 254, 1'b1, 1'b1};
    ovl[3] = '{80, 254, 1'b1, 1'b0};
    ovl[4] = '{50, 224, 1'b1, 1'b0};
    ovl[5] = '{79, 255, 1'b1, 1'b0};
    ovl[6] = '{60, 240, 1'b0, 1'b0};
    ovl[7] = '{60, 240, 1'b1, 1'b1};

    // Manual moves on A from (50,225), one tick per row.
    man[0] = '{1, 0, 0, 0, 54, 225, 1, 1};
    man[1] = '{0, 1, 0, 0, 50, 225, 0, 1};
    man[2] = '{1, 1, 0, 0, 50, 225, 0, 1};
    man[3] = '{0, 0, 0, 1, 50, 229, 0, 1};
    man[4] = '{0, 0, 1, 0, 50, 225, 0, 0};
    man[5] = '{0, 0, 1, 1, 50, 225, 0, 0};
    man[6] = '{0, 0, 0, 0, 50, 225, 0, 0};
    man[7] = '{1, 0, 0, 1, 54, 229, 1, 1};

    // Reset: move A away, then pull reset mid-count.
    do_reset(1'b0);
    apply_stimulus(0, 1, 1, 0);
    next_tick();
    next_tick();
    check_output("pre_reset_x", int'(a_x), 42);
    apply_stimulus(0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_output("reset_x", int'(a_x), 50);
    check_output("reset_y", int'(a_y), 225);
    check_output("reset_dir_x", int'(a_dx), 1);
    check_output("reset_dir_y", int'(a_dy), 1);
    check_output("reset_bounce", int'(a_bc), 0);
    check_output("reset_tick", int'(a_tick), 0);
    @(negedge clk);
    rst = 1'b1;
    first_edge = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (a_tick) begin
        first_edge = i + 1;
        break;
      end
    end
    check_output("first_tick_edge", first_edge, 4);
    @(posedge clk);
    #1;
    check_output("idle_hold_x", int'(a_x), 50);

    // Overlay table with A parked at (50,225).
    for (int i = 0; i < 8; i++) begin
      xPixel = 10'(ovl[i].xp);
      yPixel = 10'(ovl[i].yp);
      active_pixels = ovl[i].act;
      #1;
      check_output($sformatf("overlay_%0d", i), int'(a_in), int'(ovl[i].exp_in));
    end
    active_pixels = 1'b0;

    // Manual move table on A.
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(man[i].r, man[i].l, man[i].u, man[i].d);
      next_tick();
      check_output($sformatf("man_x_%0d", i), int'(a_x), man[i].ex);
      check_output($sformatf("man_y_%0d", i), int'(a_y), man[i].ey);
      check_output($sformatf("man_dx_%0d", i), int'(a_dx), int'(man[i].edx));
      check_output($sformatf("man_dy_%0d", i), int'(a_dy), int'(man[i].edy));
    end
    check_output("man_no_bounce", int'(a_bc), 0);

    // Left floor: A from 54 down to 2, then clamps at 0.
    apply_stimulus(0, 1, 0, 0);
    for (int i = 0; i < 13; i++) next_tick();
    check_output("floor_pre", int'(a_x), 2);
    next_tick();
    check_output("floor_zero", int'(a_x), 0);
    next_tick();
    check_output("floor_hold", int'(a_x), 0);
    check_output("floor_dir", int'(a_dx), 0);
    apply_stimulus(0, 0, 0, 0);

    // Manual clamp on B from 608, then auto bounce while parked at the limit.
    do_reset(1'b0);
    apply_stimulus(1, 0, 0, 0);
    next_tick();
    check_output("clamp_t1", int'(b_x), 610);
    next_tick();
    check_output("clamp_t2", int'(b_x), 610);
    next_tick();
    check_output("clamp_t3", int'(b_x), 610);
    apply_stimulus(1, 1, 0, 0);
    next_tick();
    check_output("clamp_both", int'(b_x), 610);
    apply_stimulus(0, 0, 0, 0);
    mode = 1'b1;
    next_tick();
    check_output("mode_edge_x", int'(b_x), 610);
    check_output("mode_edge_dir", int'(b_dx), 1);
    next_tick();
    check_output("parked_x", int'(b_x), 610);
    check_output("parked_dir", int'(b_dx), 0);
    check_output("parked_bounce", int'(b_bc), 1);

    // Auto bounce on A: walk to 602 manually, then switch to auto.
    do_reset(1'b0);
    apply_stimulus(1, 0, 0, 0);
    for (int i = 0; i < 138; i++) next_tick();
    check_output("walk_x", int'(a_x), 602);
    apply_stimulus(0, 0, 0, 0);
    mode = 1'b1;
    next_tick();
    check_output("switch_x", int'(a_x), 602);
    next_tick();
    check_output("auto_x1", int'(a_x), 606);
    check_output("auto_bc1", int'(a_bc), 0);
    next_tick();
    check_output("auto_x2", int'(a_x), 610);
    check_output("auto_dir2", int'(a_dx), 0);
    check_output("auto_bc2", int'(a_bc), 1);
    check_output("auto_y2", int'(a_y), 233);
    check_output("auto_corner2", int'(a_corner), 0);
    next_tick();
    check_output("auto_x3", int'(a_x), 606);
    check_output("auto_y3", int'(a_y), 237);

    // Corner on C, reset straight into auto mode.
    do_reset(1'b1);
    #1;
    check_output("c_reset_x", int'(c_x), 606);
    check_output("c_reset_y", int'(c_y), 446);
    next_tick();
    check_output("auto_reset_a_x", int'(a_x), 54);
    check_output("corner_x", int'(c_x), 610);
    check_output("corner_y", int'(c_y), 450);
    check_output("corner_dx", int'(c_dx), 0);
    check_output("corner_dy", int'(c_dy), 0);
    check_output("corner_bc", int'(c_bc), 1);
    check_output("corner_pulse", int'(c_corner), 1);
    @(posedge clk);
    #1;
    check_output("corner_pulse_end", int'(c_corner), 0);
    next_tick();
    check_output("corner_back_x", int'(c_x), 606);
    check_output("corner_back_y", int'(c_y), 446);
    check_output("corner_back_bc", int'(c_bc), 1);
    check_output("corner_back_pulse", int'(c_corner), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
